mul_issue: RTL and testbench
============================

# mul_issue

Issue/retire controller sitting directly upstream of the multiply unit `mu` in the execute stage. Accepts RV32M multiply requests (MUL/MULH/MULHSU/MULHU) from decode/execute and stalls the pipeline while busy. Drives `mu` with a one-cycle strobe, waits for its `valid`, and returns a single-cycle writeback pulse. Includes a one-entry result cache so a repeated identical request retires without re-issuing, and handles flush, drain and timeout.

## Interface
- `TIMEOUT`, 64: maximum cycles in WAIT before the op is aborted.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 1: request valid from execute.
- `funct3` in 3: RV32M funct3; only 3'b000..3'b011 are accepted.
- `rs1`, `rs2` in 32: operands.
- `rd` in 5: destination register.
- `flush` in 1: abandon the current op; no writeback.
- `ready` out 1: high only in IDLE; `req & ready & !funct3[2]` = accept.
- `busy` out 1: pipeline stall, equal to `req & !ready` or any non-IDLE state.
- `mu_strb` out 1: to `mu.strb`.
- `mu_a`, `mu_b` out 32: to `mu.a` and `mu.b`.
- `mu_ctl` out 2: to `mu.mulctl`.
  - 00 = MUL, 01 = MULH, 10 = MULHSU, 11 = MULHU.
  - Equal to `funct3[1:0]`.
- `mu_res` in 32: from `mu.mulres`.
- `mu_valid` in 1: from `mu.valid`.
- `wb_valid` out 1: one-cycle retire pulse.
- `wb_rd` out 5: destination register for the retire.
- `wb_data` out 32: result data.
- `wb_err` out 1: timeout flag, qualified by `wb_valid`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- Reset values:
  - State IDLE; cache invalid.
  - All outputs 0 except `ready` = 1.
  - `mu_a`, `mu_b`, `mu_ctl` registers = 0; timeout counter = 0.
- **IDLE, on accept:** latch `rs1`, `rs2`, `funct3[1:0]` and `rd` into op registers.
  - `rd` = 0: go to DONE with data 0. `mu` is not issued and the cache is unchanged.
  - Cache hit (cache valid, same ctl, same `rs1`, same `rs2`): go to DONE with the cached data.
  - Otherwise: go to ISSUE.
- **IDLE, `req` with `funct3[2]` = 1:** not accepted; `ready` stays 1 and `busy` = 0. Divide is owned elsewhere.
- **ISSUE:** `mu_strb` = 1 for exactly this cycle; clear the counter; go to WAIT.
  - `mu_valid` is ignored in this cycle because it may be stale.
- **WAIT:** `mu_a`/`mu_b`/`mu_ctl` are held stable; the counter increments each cycle.
  - First cycle with `mu_valid` = 1: capture `mu_res` into the result and the cache (mark valid); go to DONE.
  - Counter reaches `TIMEOUT - 1` with no `mu_valid`: result = 0, set error; go to DONE; cache invalidated.
- **DONE:** `wb_valid` = 1 with `wb_rd`/`wb_data`/`wb_err`; next state IDLE.
- **Flush:**
  - In ISSUE or WAIT: go to DRAIN, with no writeback.
  - In DONE: suppress `wb_valid`; go to IDLE.
  - In IDLE: no effect. A simultaneous `req` is not accepted.
- **DRAIN:**
  - Wait for `mu_valid`, discard it, go to IDLE; cache not updated.
  - Also exits after `TIMEOUT` cycles.
  - `ready` = 0 throughout.
- **Simultaneous `mu_valid` and `flush` in WAIT:** flush wins; the result is discarded; go directly to IDLE.
- Any reset, including mid-op: immediately IDLE, cache invalid, `wb_valid` = 0, `mu_strb` = 0.

## Timing
- Accept in cycle N. A miss gives `mu_strb` in N+1, capture in the first cycle M ≥ N+2 with `mu_valid`, and `wb_valid` in M+1.
- Cache hit or `rd` = 0: `wb_valid` in N+1; `ready` again in N+2.
- `ready` is registered from state; there is no combinational path from `req` to `ready`.
- Back-to-back: minimum spacing between accepts is 2 cycles for a hit and 4 + mu-latency cycles for a miss.
- Timeout: `wb_valid` with `wb_err` = 1 in cycle N+2+TIMEOUT.
- `wb_*` are registered outputs. `wb_rd`/`wb_data` hold their last value when `wb_valid` = 0.

## Structure
- Shared package `mext_pkg`:
  - `mul_ctl_t` (2-bit) with constants `MULCTL_MUL`, `MULCTL_MULH`, `MULCTL_MULHSU`, `MULCTL_MULHU`.
  - `FUNCT3_DIV_BIT` = 2.
  - State enum `mul_issue_state_t`.
- One sub-module, `mul_rcache`: 1-entry tag/data register with `lookup`, `fill` and `invalidate` ports. It keeps the cache logic isolated for later widening.

## Test plan
- rs1 = -3, rs2 = -4 for each op:
  - MUL → `wb_data` = 12.
  - MULH → 0.
  - MULHSU → 0xFFFFFFFD.
  - MULHU → 0xFFFFFFF9.
  - Each op gives exactly one `mu_strb` pulse and one `wb_valid` pulse with the correct `wb_rd`.
- MUL 16 × 48 → 768 (miss). Repeat the identical request → 768 with `wb_valid` one cycle after accept and no `mu_strb`.
- `rd` = 0, and separately `funct3` = 3'b100:
  - `rd` = 0 → `wb_data` = 0, no strobe.
  - `funct3` = 3'b100 → never accepted, `busy` = 0.
- Flush in WAIT, `mu_valid` two cycles later → no `wb_valid`; DRAIN consumes `mu_valid`; next request MUL 2 × 3 → 6; cache not polluted.
- Stub `mu` never raises valid, with `TIMEOUT` = 8 → `wb_valid` with `wb_err` = 1, data 0, in cycle N+10.
- Assert `rst` in WAIT → outputs return to reset values immediately; a later `mu_valid` is ignored; the subsequent identical request misses and strobes.

Source files
------------

// File: rtl/mext_pkg.sv
// Shared RV32M execute-stage types: multiply control encoding and issue FSM states.
package mext_pkg;

    typedef logic [1:0] mul_ctl_t;

    localparam mul_ctl_t MULCTL_MUL    = 2'b00;
    localparam mul_ctl_t MULCTL_MULH   = 2'b01;
    localparam mul_ctl_t MULCTL_MULHSU = 2'b10;
    localparam mul_ctl_t MULCTL_MULHU  = 2'b11;

    localparam int FUNCT3_DIV_BIT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } mul_issue_state_t;

endpackage

// File: rtl/mul_rcache.sv
// One-entry multiply result cache, tagged by control and both operands.
module mul_rcache
    import mext_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup,
    input  logic [1:0]  lookup_ctl,
    input  logic [31:0] lookup_a,
    input  logic [31:0] lookup_b,
    output logic        hit,
    output logic [31:0] hit_data,
    input  logic        fill,
    input  logic [1:0]  fill_ctl,
    input  logic [31:0] fill_a,
    input  logic [31:0] fill_b,
    input  logic [31:0] fill_data,
    input  logic        invalidate
);

    logic        vld;
    mul_ctl_t    tag_ctl;
    logic [31:0] tag_a;
    logic [31:0] tag_b;
    logic [31:0] data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld     <= 1'b0;
            tag_ctl <= MULCTL_MUL;
            tag_a   <= '0;
            tag_b   <= '0;
            data    <= '0;
        end else if (invalidate) begin
            vld <= 1'b0;
        end else if (fill) begin
            vld     <= 1'b1;
            tag_ctl <= fill_ctl;
            tag_a   <= fill_a;
            tag_b   <= fill_b;
            data    <= fill_data;
        end
    end

    assign hit      = lookup && vld && (tag_ctl == lookup_ctl) &&
                      (tag_a == lookup_a) && (tag_b == lookup_b);
    assign hit_data = data;

endmodule

// File: rtl/mul_issue.sv
// Issue/retire controller in front of the multiply unit: strobes mu, waits for
// its result (with timeout), and retires through a one-cycle writeback pulse.
module mul_issue
    import mext_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [4:0]  rd,
    input  logic        flush,
    output logic        ready,
    output logic        busy,
    output logic        mu_strb,
    output logic [31:0] mu_a,
    output logic [31:0] mu_b,
    output logic [1:0]  mu_ctl,
    input  logic [31:0] mu_res,
    input  logic        mu_valid,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    mul_issue_state_t state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [4:0]       op_rd;
    logic             accept;
    logic             rd_zero;
    logic             hit;
    logic [31:0]      hit_data;
    logic             tmo;
    logic             fill;
    logic             inval;

    assign accept  = (state == S_IDLE) && req && !funct3[FUNCT3_DIV_BIT] && !flush;
    assign rd_zero = (rd == 5'd0);
    assign tmo     = (cnt == CW'(TIMEOUT - 1));
    assign fill    = (state == S_WAIT) && mu_valid && !flush;
    assign inval   = (state == S_WAIT) && !mu_valid && !flush && tmo;

    assign ready    = (state == S_IDLE);
    assign busy     = (req && !ready) || (state != S_IDLE);
    assign mu_strb  = (state == S_ISSUE);
    assign wb_valid = (state == S_DONE) && !flush;

    mul_rcache u_rcache (
        .clk        (clk),
        .rst        (rst),
        .lookup     (accept && !rd_zero),
        .lookup_ctl (funct3[1:0]),
        .lookup_a   (rs1),
        .lookup_b   (rs2),
        .hit        (hit),
        .hit_data   (hit_data),
        .fill       (fill),
        .fill_ctl   (mu_ctl),
        .fill_a     (mu_a),
        .fill_b     (mu_b),
        .fill_data  (mu_res),
        .invalidate (inval)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (rd_zero || hit) ? S_DONE : S_ISSUE;
            S_ISSUE: state_nxt = flush ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                // A result arriving together with flush is simply dropped.
                if (flush)              state_nxt = mu_valid ? S_IDLE : S_DRAIN;
                else if (mu_valid || tmo) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_DRAIN: if (mu_valid || tmo) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mu_a    <= '0;
            mu_b    <= '0;
            mu_ctl  <= '0;
            op_rd   <= '0;
            cnt     <= '0;
            wb_rd   <= '0;
            wb_data <= '0;
            wb_err  <= 1'b0;
        end else begin
            if (accept) begin
                mu_a   <= rs1;
                mu_b   <= rs2;
                mu_ctl <= funct3[1:0];
                op_rd  <= rd;
            end
            if (state == S_ISSUE || (state_nxt == S_DRAIN && state != S_DRAIN))
                cnt <= '0;
            else if (state == S_WAIT || state == S_DRAIN)
                cnt <= cnt + CW'(1);
            // Writeback registers load only on entry to DONE so they hold between retires.
            if (state_nxt == S_DONE && state != S_DONE) begin
                if (state == S_IDLE) begin
                    wb_rd   <= rd;
                    wb_data <= rd_zero ? 32'd0 : hit_data;
                    wb_err  <= 1'b0;
                end else begin
                    wb_rd   <= op_rd;
                    wb_data <= mu_valid ? mu_res : 32'd0;
                    wb_err  <= !mu_valid;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_issue.sv
// Self-checking bench for mul_issue with a behavioural multiply-unit stub.
module tb_mul_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1 = '0, rs2 = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;
    logic        ready, busy, mu_strb;
    logic [31:0] mu_a, mu_b;
    logic [1:0]  mu_ctl;
    logic [31:0] mu_res = '0;
    logic        mu_valid = 1'b0;
    logic        wb_valid, wb_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    mul_issue #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .rd(rd), .flush(flush), .ready(ready), .busy(busy), .mu_strb(mu_strb),
        .mu_a(mu_a), .mu_b(mu_b), .mu_ctl(mu_ctl), .mu_res(mu_res),
        .mu_valid(mu_valid), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_strb = 0, n_wb = 0, wb_cyc = 0;
    int mu_lat = 2;
    int mu_cd = 0;
    logic [31:0] mu_pend = '0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          strb;
        int          lat;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mref(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (c == 2'b01 || c == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        eb = (c == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = ea * eb;
        return (c == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Multiply-unit stub: valid appears mu_lat+1 cycles after the strobe; mu_lat = 0 never answers.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mu_valid <= 1'b0;
        if (mu_strb && mu_lat > 0) begin
            mu_cd   <= mu_lat;
            mu_pend <= mref(mu_ctl, mu_a, mu_b);
        end else if (mu_cd > 0) begin
            mu_cd <= mu_cd - 1;
            if (mu_cd == 1) begin
                mu_valid <= 1'b1;
                mu_res   <= mu_pend;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mu_strb) n_strb++;
            if (wb_valid) begin
                n_wb++;
                wb_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                    chk("wb_data", wb_data, e.data);
                    chk("wb_err", {31'd0, wb_err}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 40 && !ready; i++) begin
            @(posedge clk); #1;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_req(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp,
                          input logic err, input int strb, input int lat);
        int s0, w0, acc;
        exp_t e;
        @(posedge clk); #1;
        wait_ready();
        s0 = n_strb; w0 = n_wb;
        e.rd = r; e.data = exp; e.err = err;
        sb.push_back(e);
        req = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd = r;
        acc = cyc;
        @(posedge clk); #1;
        req = 1'b0;
        for (int i = 0; i < 40 && n_wb == w0; i++) begin
            @(posedge clk); #2;
        end
        if (n_wb == w0) begin
            chk({name, "_wb_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end else begin
            chk({name, "_latency"}, wb_cyc - acc, lat);
        end
        chk({name, "_strobes"}, n_strb - s0, strb);
    endtask

    initial begin
        tbl[0] = '{3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd1, 32'd12,         1, 5};
        tbl[1] = '{3'b001, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd2, 32'd0,          1, 5};
        tbl[2] = '{3'b010, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd3, 32'hFFFF_FFFD,  1, 5};
        tbl[3] = '{3'b011, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 5'd4, 32'hFFFF_FFF9,  1, 5};
        tbl[4] = '{3'b000, 32'd16,        32'd48,        5'd5, 32'd768,        1, 5};
        tbl[5] = '{3'b000, 32'd16,        32'd48,        5'd6, 32'd768,        0, 1};
        tbl[6] = '{3'b000, 32'd5,         32'd7,         5'd0, 32'd0,          0, 1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_mu_strb", {31'd0, mu_strb}, 32'd0);
        chk("rst_mu_a", mu_a, 32'd0);
        chk("rst_mu_ctl", {30'd0, mu_ctl}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        mu_lat = 2;
        for (int i = 0; i < 7; i++)
            do_req($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd,
                   tbl[i].exp, 1'b0, tbl[i].strb, tbl[i].lat);

        // Divide funct3 is never accepted.
        begin
            int s0, w0;
            @(posedge clk); #1;
            s0 = n_strb; w0 = n_wb;
            req = 1'b1; funct3 = 3'b100; rs1 = 32'd9; rs2 = 32'd3; rd = 5'd7;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("div_ready", {31'd0, ready}, 32'd1);
                chk("div_busy", {31'd0, busy}, 32'd0);
                @(posedge clk); #1;
            end
            req = 1'b0;
            repeat (4) @(posedge clk); #1;
            chk("div_no_strobe", n_strb - s0, 32'd0);
            chk("div_no_wb", n_wb - w0, 32'd0);
        end

        // Flush in WAIT; mu_valid lands two cycles later in DRAIN.
        begin
            int s0, w0;
            mu_lat = 2;
            @(posedge clk); #1;
            s0 = n_strb; w0 = n_wb;
            req = 1'b1; funct3 = 3'b000; rs1 = 32'd7; rs2 = 32'd9; rd = 5'd3;
            @(posedge clk); #1; req = 1'b0;
            @(posedge clk); #1; flush = 1'b1;
            @(posedge clk); #1; flush = 1'b0;
            @(negedge clk);
            chk("drain_ready", {31'd0, ready}, 32'd0);
            repeat (8) @(posedge clk); #1;
            chk("flush_no_wb", n_wb - w0, 32'd0);
            chk("flush_strobes", n_strb - s0, 32'd1);
            chk("flush_ready", {31'd0, ready}, 32'd1);
        end
        do_req("after_flush", 3'b000, 32'd2, 32'd3, 5'd8, 32'd6, 1'b0, 1, 5);
        do_req("no_pollute", 3'b000, 32'd7, 32'd9, 5'd3, 32'd63, 1'b0, 1, 5);

        // Reset asserted while waiting on mu.
        begin
            int w0;
            mu_lat = 4;
            @(posedge clk); #1;
            req = 1'b1; funct3 = 3'b000; rs1 = 32'd100; rs2 = 32'd3; rd = 5'd4;
            @(posedge clk); #1; req = 1'b0;
            @(posedge clk); #1; rst = 1'b1;
            #1;
            chk("midrst_ready", {31'd0, ready}, 32'd1);
            chk("midrst_busy", {31'd0, busy}, 32'd0);
            chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
            chk("midrst_mu_strb", {31'd0, mu_strb}, 32'd0);
            chk("midrst_mu_a", mu_a, 32'd0);
            @(posedge clk); #1; rst = 1'b0;
            w0 = n_wb;
            repeat (8) @(posedge clk); #1;
            chk("midrst_no_wb", n_wb - w0, 32'd0);
        end
        do_req("rst_cache_inval", 3'b000, 32'd7, 32'd9, 5'd3, 32'd63, 1'b0, 1, 7);
        do_req("rst_retry", 3'b000, 32'd100, 32'd3, 5'd4, 32'd300, 1'b0, 1, 7);

        // mu never answers: timeout retire with error at N+2+TIMEOUT.
        mu_lat = 0;
        do_req("timeout", 3'b000, 32'd9, 32'd9, 5'd6, 32'd0, 1'b1, 1, 10);
        mu_lat = 3;
        do_req("post_timeout", 3'b000, 32'd9, 32'd9, 5'd6, 32'd81, 1'b0, 1, 6);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
